// File: rtl/wrapper.sv
// wrapper: counts debounced BTND presses in a 4-bit counter and shows it as hex on an active-low seven-segment digit.
// Define WRAPPER_SATURATE_EN to hold the count at F instead of wrapping to 0.
module wrapper #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLK100MHZ,
    input  logic BTNC,
    input  logic BTND,
    output logic CA,
    output logic CB,
    output logic CC,
    output logic CD,
    output logic CE,
    output logic CF,
    output logic CG
);
    localparam logic [23:0] LAST = 24'(DEBOUNCE_CYCLES - 1);
    logic        sync1_q, sync2_q;
    logic        level_q, level_d;
    logic        edge_q, press_q, press_d;
    logic [23:0] db_q, db_d;
    logic [3:0]  count_q, count_d;
    logic [6:0]  seg_q, seg_d;
    logic        differ, hit;
    always_comb begin
        differ  = sync2_q != level_q;
        hit     = differ && db_q == LAST;
        db_d    = (!differ || hit) ? 24'd0 : db_q + 24'd1;
        level_d = hit ? sync2_q : level_q;
        press_d = level_q && !edge_q;
`ifdef WRAPPER_SATURATE_EN
        count_d = (press_q && count_q != 4'hF) ? count_q + 4'd1 : count_q;
`else
        count_d = press_q ? count_q + 4'd1 : count_q;
`endif
    end
    // Segment order is {CA..CG}, 0 = lit
    always_comb begin
        seg_d = 7'b1111111;
        case (count_q)
            4'h0: seg_d = 7'b0000001;
            4'h1: seg_d = 7'b1001111;
            4'h2: seg_d = 7'b0010010;
            4'h3: seg_d = 7'b0000110;
            4'h4: seg_d = 7'b1001100;
            4'h5: seg_d = 7'b0100100;
            4'h6: seg_d = 7'b0100000;
            4'h7: seg_d = 7'b0001111;
            4'h8: seg_d = 7'b0000000;
            4'h9: seg_d = 7'b0000100;
            4'hA: seg_d = 7'b0001000;
            4'hB: seg_d = 7'b1100000;
            4'hC: seg_d = 7'b0110001;
            4'hD: seg_d = 7'b1000010;
            4'hE: seg_d = 7'b0110000;
            4'hF: seg_d = 7'b0111000;
            default: seg_d = 7'b1111111;
        endcase
    end
    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            db_q    <= 24'd0;
            edge_q  <= 1'b0;
            press_q <= 1'b0;
            count_q <= 4'd0;
            seg_q   <= 7'b0000001;
        end else begin
            sync1_q <= BTND;
            sync2_q <= sync1_q;
            level_q <= level_d;
            db_q    <= db_d;
            edge_q  <= level_q;
            press_q <= press_d;
            count_q <= count_d;
            seg_q   <= seg_d;
        end
    end
    assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
endmodule

// File: tb/tb_wrapper.sv
// tb_wrapper: directed checks of reset, debounce latency, glitch rejection, wrap/saturate and release handling.
module tb_wrapper;
    logic clk = 1'b0;
    logic btnc = 1'b1;
    logic btnd = 1'b0;
    logic ca, cb, cc, cd, ce, cf, cg;
    logic [6:0] seg;
    int n_checks = 0;
    int n_fail = 0;
    logic [6:0] pat [16];

    wrapper #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK100MHZ(clk), .BTNC(btnc), .BTND(btnd),
        .CA(ca), .CB(cb), .CC(cc), .CD(cd), .CE(ce), .CF(cf), .CG(cg)
    );

    always #5 clk = ~clk;
    assign seg = {ca, cb, cc, cd, ce, cf, cg};

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        btnd = 1'b0;
        btnc = 1'b1;
        step(3);
        btnc = 1'b0;
    endtask

    task automatic press_release(input int hi, input int lo);
        btnd = 1'b1;
        step(hi);
        btnd = 1'b0;
        step(lo);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            n_checks++;
            if (seg !== 7'b0000001) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %b expected %b", i, seg, 7'b0000001);
            end
            step(1);
        end
    endtask

    task automatic test_single_press();
        do_reset();
        step(2);
        btnd = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            step(1);
            n_checks++;
            if (seg !== (e < 8 ? pat[0] : pat[1])) begin
                n_fail++;
                $display("FAIL single_press_latency after E%0d: got %b expected %b", e, seg, e < 8 ? pat[0] : pat[1]);
            end
        end
        for (int i = 0; i < 30; i++) begin
            step(1);
            n_checks++;
            if (seg !== pat[1]) begin
                n_fail++;
                $display("FAIL single_press_hold cycle %0d: got %b expected %b", i, seg, pat[1]);
            end
        end
        btnd = 1'b0;
        step(20);
    endtask

    task automatic test_glitch();
        do_reset();
        step(2);
        press_release(3, 30);
        n_checks++;
        if (seg !== pat[0]) begin
            n_fail++;
            $display("FAIL glitch_rejected: got %b expected %b", seg, pat[0]);
        end
    endtask

    task automatic test_sixteen();
        logic [6:0] exp;
        do_reset();
        step(2);
        for (int i = 1; i <= 16; i++) begin
            press_release(10, 10);
`ifdef WRAPPER_SATURATE_EN
            exp = pat[i > 15 ? 15 : i];
`else
            exp = pat[i % 16];
`endif
            n_checks++;
            if (seg !== exp) begin
                n_fail++;
                $display("FAIL sixteen_press %0d: got %b expected %b", i, seg, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(2);
        for (int i = 0; i < 5; i++) press_release(10, 10);
        n_checks++;
        if (seg !== pat[5]) begin
            n_fail++;
            $display("FAIL reset_mid_precount: got %b expected %b", seg, pat[5]);
        end
        btnd = 1'b1;
        step(3);
        btnc = 1'b1;
        step(1);
        btnc = 1'b0;
        n_checks++;
        if (seg !== pat[0]) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got %b expected %b", seg, pat[0]);
        end
        for (int e = 0; e <= 8; e++) begin
            step(1);
            n_checks++;
            if (seg !== (e < 8 ? pat[0] : pat[1])) begin
                n_fail++;
                $display("FAIL reset_mid_fresh after E%0d: got %b expected %b", e, seg, e < 8 ? pat[0] : pat[1]);
            end
        end
        btnd = 1'b0;
        step(20);
    endtask

    task automatic test_release();
        do_reset();
        step(2);
        press_release(10, 10);
        btnd = 1'b1;
        step(20);
        n_checks++;
        if (seg !== pat[2]) begin
            n_fail++;
            $display("FAIL release_hold: got %b expected %b", seg, pat[2]);
        end
        btnd = 1'b0;
        step(20);
        n_checks++;
        if (seg !== pat[2]) begin
            n_fail++;
            $display("FAIL release_not_counted: got %b expected %b", seg, pat[2]);
        end
    endtask

    initial begin
        pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        test_reset();
        test_single_press();
        test_glitch();
        test_sixteen();
        test_reset_mid();
        test_release();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wrapper.md
Name: wrapper

Overview:
- FPGA board-level top for a 100 MHz board with pushbuttons and one active-low seven-segment digit.
- Counts debounced presses of BTND in a 4-bit counter and shows the count as a hex digit on segments CA..CG.
- BTNC is the system reset.
- No submodules are required; synchronizer, debouncer, edge detector, counter and decoder all live in this block.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles the synchronized BTND must hold a new level before it is accepted (10 ms at 100 MHz). Legal range is 1 to 2^24-1.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz; all logic is on its rising edge.
- BTNC  input  1  reset; synchronous, active-high.
- BTND  input  1  asynchronous, bouncy pushbutton; high = pressed.
- CA  output  1  segment a, active-low (0 = lit).
- CB  output  1  segment b, active-low.
- CC  output  1  segment c, active-low.
- CD  output  1  segment d, active-low.
- CE  output  1  segment e, active-low.
- CF  output  1  segment f, active-low.
- CG  output  1  segment g, active-low.

Behaviour:
- Reset (BTNC high at a clock edge), applied to all state:
  - sync flops = 0, debounced level = 0, debounce counter = 0, edge register = 0, count = 0.
  - Segment registers load the pattern for "0": CA..CF = 0, CG = 1.
  - Reset wins over every other event in the same cycle, including a pending debounce flip or count increment.
- Synchronizer: BTND passes through two flops, sync1 then sync2. Only sync2 is used downstream.
- Debouncer: a 24-bit counter.
  - Each cycle in which sync2 equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 while sync2 still differs, the debounced level takes sync2 and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Edge detect: a registered pulse, press, is high for exactly one cycle, the cycle after the debounced level goes 0->1. Release (1->0) produces no pulse.
- Counter: 4-bit count increments by 1 on the edge where press = 1. It wraps F -> 0 (see Optional Feature).
- Display: the segment outputs are registered and load decode(count) every cycle.
  - Patterns are given as CA..CG, 0 = lit.
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- Latency, with N = DEBOUNCE_CYCLES: BTND rises and stays high before edge E0.
  - sync2 = 1 after E1.
  - Debounced level = 1 after E(1+N).
  - press = 1 after E(2+N).
  - count updated after E(3+N).
  - Segments updated after E(4+N).
- Holding BTND high yields exactly one increment. A new increment requires a debounced release followed by a debounced press.
- After a reset deassertion with BTND held high, BTND is treated as a fresh press and counts once after full latency.

Optional Feature:
- Macro: WRAPPER_SATURATE_EN.
- Defined: the count saturates at F. A press while count = F leaves it at F and the display stays "F".
- Not defined: the count wraps F -> 0 and the display shows "0".

Test Plan:
- Reset check: drive BTNC high for 3 edges with BTND = 0, then low.
  - Required: segments {CA..CG} = 0000001 and stay so for 100 cycles.
- Single press, DEBOUNCE_CYCLES = 4: hold BTND = 1.
  - Required: segments change to 1001111 exactly 8 edges after BTND rises (after E8), and no further change while BTND is held.
- Glitch rejection, N = 4: pulse BTND high for 3 cycles, then low.
  - Required: display remains "0".
- Sixteen full presses: each press is 10 cycles high and 10 cycles low, N = 4.
  - Required: display walks 1, 2, ..., F, then shows "0" (or stays "F" with WRAPPER_SATURATE_EN).
- Reset mid-operation: at count = 5, assert BTNC for 1 cycle while a debounce is in progress.
  - Required: display returns to 0000001 on the next edge and the in-progress press is discarded.
- Release is not counted: press, hold 20 cycles, release, hold low 20 cycles.
  - Required: count increments by exactly 1.
